// File: rtl/pwmled_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwmled_pkg : register map, CTRL fields and breathe direction type          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package pwmled_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_DUTY0    = 2;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_BREATHE_LSB = 16;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage
`default_nettype wire

// File: rtl/pwmled_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwmled_channel : effective duty, breathe FSM and output compare register   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module pwmled_channel
  import pwmled_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 wrap,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [CNT_WIDTH-1:0] duty,
  input  logic                 breathe,
  output logic                 pwm
);

  localparam logic [CNT_WIDTH-1:0] E_MAX       = '1;
  localparam logic [CNT_WIDTH-1:0] E_MIN       = '0;
  localparam logic [CNT_WIDTH-1:0] E_BELOW_MAX = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] E_ABOVE_MIN = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  dir_t                 dir;
  dir_t                 dir_cur;
  dir_t                 dir_next;
  logic [CNT_WIDTH-1:0] eff;
  logic [CNT_WIDTH-1:0] eff_next;
  logic                 breathe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir       <= UP;
      eff       <= '0;
      breathe_q <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      dir       <= dir_next;
      eff       <= eff_next;
      breathe_q <= breathe;
      pwm       <= enable && (cnt < eff);
    end
  end

  // On entering breathe mode the fade continues from the current duty.
  always_comb begin
    dir_cur = dir;
    if (breathe && !breathe_q) begin
      dir_cur = (eff == E_MAX) ? DOWN : UP;
    end
    dir_next = dir_cur;
    eff_next = eff;
    if (wrap) begin
      if (!breathe) begin
        eff_next = duty;
      end else if (dir_cur == UP) begin
        if (eff == E_MAX) begin
          eff_next = eff - 1'b1;
          dir_next = DOWN;
        end else begin
          eff_next = eff + 1'b1;
          if (eff == E_BELOW_MAX) dir_next = DOWN;
        end
      end else begin
        if (eff == E_MIN) begin
          eff_next = eff + 1'b1;
          dir_next = UP;
        end else begin
          eff_next = eff - 1'b1;
          if (eff == E_ABOVE_MIN) dir_next = UP;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwmled_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwmled_array : Avalon-MM multi-channel LED PWM with shared period counter  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module pwmled_array
  import pwmled_pkg::*;
#(
  parameter  int CHANNELS       = 4,
  parameter  int CNT_WIDTH      = 8,
  parameter  int PRESCALE_WIDTH = 16,
  localparam int ADDR_W         = $clog2(CHANNELS + 2)
) (
  input  logic                clock_100m,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [ADDR_W-1:0]    A_CTRL     = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0]    A_PRESCALE = ADDR_W'(ADDR_PRESCALE);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  logic                      enable;
  logic [CHANNELS-1:0]       breathe_mask;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [CNT_WIDTH-1:0]      duty [CHANNELS];
  logic [31:0]               rd_word;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic [CNT_WIDTH-1:0]      cnt;
  logic                      tick;
  logic                      wrap;
  logic                      unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Register bank
  always_ff @(posedge clock_100m or negedge reset_n) begin
    if (!reset_n) begin
      enable       <= 1'b0;
      breathe_mask <= '0;
      prescale     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= '0;
      end
    end else if (avs_write) begin
      if (avs_address == A_CTRL) begin
        enable       <= avs_writedata[CTRL_EN];
        breathe_mask <= avs_writedata[CTRL_BREATHE_LSB +: CHANNELS];
      end
      if (avs_address == A_PRESCALE) begin
        prescale <= avs_writedata[PRESCALE_WIDTH-1:0];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (avs_address == ADDR_W'(ADDR_DUTY0 + i)) begin
          duty[i] <= avs_writedata[CNT_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (avs_address == A_CTRL) begin
      rd_word[CTRL_EN]                       = enable;
      rd_word[CTRL_BREATHE_LSB +: CHANNELS] = breathe_mask;
    end
    if (avs_address == A_PRESCALE) begin
      rd_word[PRESCALE_WIDTH-1:0] = prescale;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (avs_address == ADDR_W'(ADDR_DUTY0 + i)) begin
        rd_word[CNT_WIDTH-1:0] = duty[i];
      end
    end
  end

  always_ff @(posedge clock_100m or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_word;
    end
  end

  // ">=" lets a shrunken prescale value wrap the prescaler immediately.
  assign tick = enable && (pre >= prescale);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clock_100m or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (!enable) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwmled_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_channel (
      .clk     (clock_100m),
      .rst_n   (reset_n),
      .enable  (enable),
      .wrap    (wrap),
      .cnt     (cnt),
      .duty    (duty[g]),
      .breathe (breathe_mask[g]),
      .pwm     (pwm_out[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pwmled_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwmled_array : directed self-checking bench for pwmled_array            |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_pwmled_array;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_PRE  = 3'd1;
  localparam logic [2:0] A_D0   = 3'd2;
  localparam logic [2:0] A_D1   = 3'd3;
  localparam logic [2:0] A_D2   = 3'd4;
  localparam logic [2:0] A_D3   = 3'd5;

  logic        clock_100m    = 1'b0;
  logic        reset_n       = 1'b0;
  logic [2:0]  avs_address   = '0;
  logic        avs_write     = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read      = 1'b0;
  logic [31:0] avs_readdata;
  logic [3:0]  pwm_out;

  int checks   = 0;
  int failures = 0;

  pwmled_array #(
    .CHANNELS       (4),
    .CNT_WIDTH      (8),
    .PRESCALE_WIDTH (16)
  ) dut (
    .clock_100m    (clock_100m),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .pwm_out       (pwm_out)
  );

  always #5 clock_100m = ~clock_100m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clock_100m);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clock_100m);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
    avs_address   = a;
    avs_writedata = wd;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    @(negedge clock_100m);
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    rd            = avs_readdata;
  endtask

  // Stops on the first sample where channel 0 rises (start of a period).
  task automatic align_rise(input int limit, input string tag);
    logic prev;
    logic found;
    found = 1'b0;
    prev  = pwm_out[0];
    for (int n = 0; n < limit && !found; n++) begin
      @(negedge clock_100m);
      if (!prev && pwm_out[0]) found = 1'b1;
      prev = pwm_out[0];
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  // Counts high samples per channel over len cycles, optionally issuing one write at index wr_at.
  task automatic window(input int len, input int wr_at, input logic [2:0] wa, input logic [31:0] wd,
                        output int h0, output int h1, output int h2, output int h3,
                        output logic [1:0] edge0);
    logic last;
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    last = 1'b0;
    for (int i = 0; i < len; i++) begin
      h0 += pwm_out[0] ? 1 : 0;
      h1 += pwm_out[1] ? 1 : 0;
      h2 += pwm_out[2] ? 1 : 0;
      h3 += pwm_out[3] ? 1 : 0;
      last = pwm_out[0];
      if (i == wr_at) begin
        avs_address   = wa;
        avs_writedata = wd;
        avs_write     = 1'b1;
      end else if (i == wr_at + 1) begin
        avs_write = 1'b0;
      end
      @(negedge clock_100m);
    end
    edge0 = {last, pwm_out[0]};
  endtask

  // Breathe sequence: per-period high time of channel 0 and the write issued inside it.
  int          b_at  [17] = '{-1, -1, -1, -1, -1, 100, 100, 100, -1, -1, -1, -1, 100, 100, 100, -1, -1};
  logic [2:0]  b_a   [17] = '{A_CTRL, A_CTRL, A_CTRL, A_CTRL, A_CTRL, A_CTRL, A_D0, A_CTRL, A_CTRL,
                              A_CTRL, A_CTRL, A_CTRL, A_CTRL, A_D0, A_CTRL, A_CTRL, A_CTRL};
  logic [31:0] b_d   [17] = '{0, 0, 0, 0, 0, 1, 252, 32'h10001, 0, 0, 0, 0, 1, 255, 32'h10001, 0, 0};
  int          b_exp [17] = '{1, 2, 3, 4, 5, 6, 0, 252, 253, 254, 255, 254, 253, 252, 255, 254, 253};

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  e0;
    logic        found;
    int          h0, h1, h2, h3;

    repeat (3) @(negedge clock_100m);
    check("rst_pwm", {28'd0, pwm_out}, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    bus_read(A_CTRL, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(A_PRE, rd);  check("rst_pre", rd, 32'd0);
    bus_read(A_D0, rd);   check("rst_duty0", rd, 32'd0);

    // Static duty and extremes
    bus_write(A_D0, 32'd64);
    bus_write(A_D1, 32'd0);
    bus_write(A_D2, 32'd255);
    bus_write(A_CTRL, 32'd1);
    bus_read(A_D0, rd);   check("rb_duty0", rd, 32'd64);
    bus_read(A_CTRL, rd); check("rb_ctrl", rd, 32'd1);
    align_rise(1000, "align_static");
    for (int k = 0; k < 3; k++) begin
      window(255, (k == 2) ? 100 : -1, A_D0, 32'd200, h0, h1, h2, h3, e0);
      check($sformatf("static_hi%0d", k), h0, 32'd64);
      check($sformatf("static_edge%0d", k), {30'd0, e0}, 32'd1);
      check($sformatf("ch1_low%0d", k), h1, 32'd0);
      check($sformatf("ch2_high%0d", k), h2, 32'd255);
      check($sformatf("ch3_low%0d", k), h3, 32'd0);
    end
    window(255, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    check("dbuf_hi", h0, 32'd200);
    check("dbuf_edge", {30'd0, e0}, 32'd1);

    // Prescaler
    bus_write(A_PRE, 32'd3);
    bus_write(A_D0, 32'd128);
    align_rise(3000, "align_pre");
    window(1020, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    check("pre_hi", h0, 32'd512);
    check("pre_edge", {30'd0, e0}, 32'd1);
    check("pre_ch2", h2, 32'd1020);
    bus_read(A_PRE, rd); check("rb_pre", rd, 32'd3);

    // Bus corner cases
    bus_rw(A_D3, 32'd77, rd); check("rw_old", rd, 32'd0);
    bus_read(A_D3, rd);       check("rw_new", rd, 32'd77);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);       check("unmapped6", rd, 32'd0);
    bus_read(3'd7, rd);       check("unmapped7", rd, 32'd0);

    // Disable and re-enable
    bus_write(A_CTRL, 32'd0);
    check("dis_lag", {31'd0, pwm_out[2]}, 32'd1);
    @(negedge clock_100m);
    check("dis_pwm", {28'd0, pwm_out}, 32'd0);
    window(50, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    check("dis_hold", h0 + h1 + h2 + h3, 32'd0);
    bus_write(A_CTRL, 32'd1);
    @(negedge clock_100m);
    window(1020, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    check("reen_hi", h0, 32'd512);
    check("reen_edge", {30'd0, e0}, 32'd1);

    // Breathe
    bus_write(A_PRE, 32'd0);
    bus_write(A_D0, 32'd0);
    window(1200, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    window(255, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    check("zero_duty", h0, 32'd0);
    bus_write(A_CTRL, 32'h10001);
    bus_read(A_CTRL, rd); check("rb_ctrl_breathe", rd, 32'h10001);
    align_rise(1000, "align_breathe");
    for (int k = 0; k < 17; k++) begin
      window(255, b_at[k], b_a[k], b_d[k], h0, h1, h2, h3, e0);
      check($sformatf("breathe_w%0d", k + 1), h0, b_exp[k]);
    end

    // Asynchronous reset with an output high
    bus_read(A_D2, rd); check("rb_duty2", rd, 32'd255);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (pwm_out[0]) found = 1'b1;
      else @(negedge clock_100m);
    end
    check("pre_rst_high", {31'd0, found}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pwm", {28'd0, pwm_out}, 32'd0);
    check("async_rst_rdata", avs_readdata, 32'd0);
    @(negedge clock_100m);
    reset_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("post_rst_reg%0d", a), rd, 32'd0);
    end
    window(300, -1, A_CTRL, 32'd0, h0, h1, h2, h3, e0);
    check("post_rst_pwm", h0 + h1 + h2 + h3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
